// File: rtl/usb_buffer_arbiter_pkg.sv
// Shared definitions for the USB packet-buffer arbiter slice.
// Contents:
//   arb_state_e            arbiter FSM encoding (ARB / USB_LOCK)
//   USB_PACKET_BUFFER_SIZE packet buffer size in bytes
//   WS_W, WS_*             write-section vector width and lane bit positions
package usb_buffer_arbiter_pkg;

  typedef enum logic {
    ARB      = 1'b0,
    USB_LOCK = 1'b1
  } arb_state_e;

  localparam int USB_PACKET_BUFFER_SIZE = 1024;

  // Write-section vector: one enable per lane, all zero means read.
  localparam int WS_W   = 3;
  localparam int WS_LO  = 0;  // bits [7:0]
  localparam int WS_MID = 1;  // bits [15:8]
  localparam int WS_HI  = 2;  // bits [31:16]

endpackage

// File: rtl/usb_buffer_arbiter_if.sv
// Bus bundle between the two requesters (CPU, USB) and the buffer arbiter.
// Per requester: req, addr, wdata, write_sections (0 = read) in;
// gnt, rdata, rvalid out. USB adds usb_lock. Status: lock_active, lock_timeout.
// Modports: slave = arbiter side, master = requester side.
interface usb_buffer_arbiter_if
  import usb_buffer_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [WS_W-1:0]   cpu_write_sections;
  logic              cpu_gnt;
  logic [31:0]       cpu_rdata;
  logic              cpu_rvalid;

  logic              usb_req;
  logic              usb_lock;
  logic [ADDR_W-1:0] usb_addr;
  logic [31:0]       usb_wdata;
  logic [WS_W-1:0]   usb_write_sections;
  logic              usb_gnt;
  logic [31:0]       usb_rdata;
  logic              usb_rvalid;

  logic              lock_active;
  logic              lock_timeout;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_write_sections,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    input  usb_req, usb_lock, usb_addr, usb_wdata, usb_write_sections,
    output usb_gnt, usb_rdata, usb_rvalid,
    output lock_active, lock_timeout
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_write_sections,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    output usb_req, usb_lock, usb_addr, usb_wdata, usb_write_sections,
    input  usb_gnt, usb_rdata, usb_rvalid,
    input  lock_active, lock_timeout
  );
endinterface

// File: rtl/usb_buffer_arbiter_ram.sv
// usb_packet_ram: single-port DEPTH_WORDS x 32 packet buffer.
// Ports: clk48; en (access this cycle); we (3 lane enables, 0 = read);
// addr; wdata; rdata (registered, updates only on a read, never reset).
module usb_packet_ram
  import usb_buffer_arbiter_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk48,
  input  logic              en,
  input  logic [WS_W-1:0]   we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk48) begin
    if (en) begin
      if (we[WS_LO])  mem[addr][7:0]   <= wdata[7:0];
      if (we[WS_MID]) mem[addr][15:8]  <= wdata[15:8];
      if (we[WS_HI])  mem[addr][31:16] <= wdata[31:16];
      if (we == '0)   rdata            <= mem[addr];
    end
  end

endmodule

// File: rtl/usb_buffer_arbiter.sv
// usb_buffer_arbiter: shares one packet RAM between a CPU port and a USB
// port. Single combinational grant per cycle, round-robin on contention,
// and a USB burst lock bounded to MAX_LOCK cycles.
// Ports: clk48 (clock), rst_n (async active-low reset),
//        bus (usb_buffer_arbiter_if.slave: both requester ports + status).
module usb_buffer_arbiter
  import usb_buffer_arbiter_pkg::*;
#(
  parameter int DEPTH_WORDS = USB_PACKET_BUFFER_SIZE / 4,
  parameter int ADDR_W      = 8,
  parameter int MAX_LOCK    = 64
) (
  input  logic                 clk48,
  input  logic                 rst_n,
  usb_buffer_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == CNT_W'(MAX_LOCK)) return c;
    return c + CNT_W'(1);
  endfunction

  arb_state_e        state, state_nx;
  logic              rr_cpu, rr_cpu_nx;     // 1: CPU wins next contention
  logic [CNT_W-1:0]  lock_cnt, lock_cnt_nx;
  logic              timeout_q, timeout_nx;
  logic              cpu_gnt, usb_gnt;

  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [WS_W-1:0]   ram_we;
  logic [31:0]       ram_rdata_p1;

  logic              cpu_vld_p1, usb_vld_p1;
  logic [31:0]       cpu_hold, usb_hold;

  always_comb begin
    state_nx    = state;
    rr_cpu_nx   = rr_cpu;
    lock_cnt_nx = lock_cnt;
    timeout_nx  = timeout_q;
    cpu_gnt     = 1'b0;
    usb_gnt     = 1'b0;
    unique case (state)
      ARB: begin
        if (bus.cpu_req && bus.usb_req) begin
          cpu_gnt   = rr_cpu;
          usb_gnt   = !rr_cpu;
          rr_cpu_nx = !rr_cpu;
        end else begin
          cpu_gnt = bus.cpu_req;
          usb_gnt = bus.usb_req;
        end
        if (usb_gnt && bus.usb_lock) begin
          state_nx    = USB_LOCK;
          lock_cnt_nx = CNT_W'(1);
        end
      end
      USB_LOCK: begin
        usb_gnt     = bus.usb_req;
        lock_cnt_nx = sat_inc(lock_cnt);
        // Dropping usb_lock ends the lock whether or not a beat is granted.
        if (!bus.usb_lock) begin
          state_nx = ARB;
        end else if (lock_cnt_nx == CNT_W'(MAX_LOCK)) begin
          state_nx   = ARB;
          timeout_nx = 1'b1;
          rr_cpu_nx  = 1'b1;
        end
      end
      default: state_nx = ARB;
    endcase
    if (!rst_n) begin
      cpu_gnt = 1'b0;
      usb_gnt = 1'b0;
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      rr_cpu    <= 1'b0;
      lock_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nx;
      rr_cpu    <= rr_cpu_nx;
      lock_cnt  <= lock_cnt_nx;
      timeout_q <= timeout_nx;
    end
  end

  always_comb begin
    ram_addr  = bus.usb_addr;
    ram_wdata = bus.usb_wdata;
    ram_we    = usb_gnt ? bus.usb_write_sections : '0;
    if (cpu_gnt) begin
      ram_addr  = bus.cpu_addr;
      ram_wdata = bus.cpu_wdata;
      ram_we    = bus.cpu_write_sections;
    end
  end

  usb_packet_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk48 (clk48),
    .en    (cpu_gnt || usb_gnt),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata_p1)
  );

  // p0 -> p1: tag the in-flight read with its port; hold last data per port.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      cpu_vld_p1 <= 1'b0;
      usb_vld_p1 <= 1'b0;
      cpu_hold   <= '0;
      usb_hold   <= '0;
    end else begin
      cpu_vld_p1 <= cpu_gnt && (bus.cpu_write_sections == '0);
      usb_vld_p1 <= usb_gnt && (bus.usb_write_sections == '0);
      if (cpu_vld_p1) cpu_hold <= ram_rdata_p1;
      if (usb_vld_p1) usb_hold <= ram_rdata_p1;
    end
  end

  assign bus.cpu_gnt      = cpu_gnt;
  assign bus.usb_gnt      = usb_gnt;
  assign bus.cpu_rvalid   = cpu_vld_p1;
  assign bus.usb_rvalid   = usb_vld_p1;
  assign bus.cpu_rdata    = cpu_vld_p1 ? ram_rdata_p1 : cpu_hold;
  assign bus.usb_rdata    = usb_vld_p1 ? ram_rdata_p1 : usb_hold;
  assign bus.lock_active  = (state == USB_LOCK);
  assign bus.lock_timeout = timeout_q;

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Directed self-checking bench for usb_buffer_arbiter.
module tb_usb_buffer_arbiter;

  logic clk48 = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  usb_buffer_arbiter_if #(.ADDR_W(8)) bus ();

  usb_buffer_arbiter #(
    .DEPTH_WORDS (256),
    .ADDR_W      (8),
    .MAX_LOCK    (64)
  ) dut (
    .clk48 (clk48),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk48 = ~clk48;

  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic [7:0] a, input logic [31:0] d, input logic [2:0] s);
    bus.cpu_req = req; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_write_sections = s;
  endtask

  task automatic set_usb(input logic req, input logic lk, input logic [7:0] a, input logic [31:0] d, input logic [2:0] s);
    bus.usb_req = req; bus.usb_lock = lk; bus.usb_addr = a; bus.usb_wdata = d; bus.usb_write_sections = s;
  endtask

  task automatic test_reset();
    set_cpu(1'b1, 8'h00, 32'h0, 3'b000);
    set_usb(1'b1, 1'b1, 8'h00, 32'h0, 3'b000);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.cpu_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_gnt: got %b need 0", bus.cpu_gnt); end
    n_cmp++; if (bus.usb_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_usb_gnt: got %b need 0", bus.usb_gnt); end
    repeat (2) tick();
    n_cmp++; if ({bus.cpu_rvalid, bus.usb_rvalid, bus.lock_active, bus.lock_timeout} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_status: got %b need 0000", {bus.cpu_rvalid, bus.usb_rvalid, bus.lock_active, bus.lock_timeout}); end
    n_cmp++; if ({bus.cpu_rdata, bus.usb_rdata} !== 64'h0) begin
      n_bad++; $display("FAIL rst_rdata: got %h need 0", {bus.cpu_rdata, bus.usb_rdata}); end
    set_cpu(1'b0, 8'h00, 32'h0, 3'b000);
    set_usb(1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_cpu_write_read();
    tick();
    set_cpu(1'b1, 8'h10, 32'hDEADBEEF, 3'b111);
    #1;
    n_cmp++; if (bus.cpu_gnt !== 1'b1) begin n_bad++; $display("FAIL cpu_wr_gnt: got %b need 1", bus.cpu_gnt); end
    tick();
    n_cmp++; if (bus.cpu_rvalid !== 1'b0) begin n_bad++; $display("FAIL cpu_wr_no_rvalid: got %b need 0", bus.cpu_rvalid); end
    set_cpu(1'b1, 8'h10, 32'h0, 3'b000);
    #1;
    n_cmp++; if (bus.cpu_gnt !== 1'b1) begin n_bad++; $display("FAIL cpu_rd_gnt: got %b need 1", bus.cpu_gnt); end
    tick();
    set_cpu(1'b0, 8'h00, 32'h0, 3'b000);
    n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL cpu_rd_data: got v=%b %h need v=1 deadbeef", bus.cpu_rvalid, bus.cpu_rdata); end
    n_cmp++; if (bus.usb_rvalid !== 1'b0) begin n_bad++; $display("FAIL cpu_rd_usb_quiet: got %b need 0", bus.usb_rvalid); end
    tick();
    n_cmp++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL cpu_rd_hold: got v=%b %h need v=0 deadbeef", bus.cpu_rvalid, bus.cpu_rdata); end
  endtask

  task automatic test_alternate();
    logic ug;
    set_usb(1'b1, 1'b0, 8'h20, 32'h12345678, 3'b111);
    tick();
    set_usb(1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    set_cpu(1'b1, 8'h10, 32'h0, 3'b000);
    set_usb(1'b1, 1'b0, 8'h20, 32'h0, 3'b000);
    for (int i = 0; i < 4; i++) begin
      ug = (i % 2 == 0);
      #1;
      n_cmp++; if ({bus.usb_gnt, bus.cpu_gnt} !== {ug, !ug}) begin
        n_bad++; $display("FAIL alt_gnt[%0d]: got usb/cpu=%b%b need %b%b", i, bus.usb_gnt, bus.cpu_gnt, ug, !ug); end
      tick();
      n_cmp++; if ({bus.usb_rvalid, bus.cpu_rvalid} !== {ug, !ug}) begin
        n_bad++; $display("FAIL alt_rvalid[%0d]: got usb/cpu=%b%b need %b%b", i, bus.usb_rvalid, bus.cpu_rvalid, ug, !ug); end
      n_cmp++; if ((ug ? bus.usb_rdata : bus.cpu_rdata) !== (ug ? 32'h12345678 : 32'hDEADBEEF)) begin
        n_bad++; $display("FAIL alt_rdata[%0d]: got %h need %h", i, ug ? bus.usb_rdata : bus.cpu_rdata,
                          ug ? 32'h12345678 : 32'hDEADBEEF); end
    end
    set_cpu(1'b0, 8'h00, 32'h0, 3'b000);
    set_usb(1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
  endtask

  task automatic test_lane_write();
    tick();
    set_usb(1'b1, 1'b0, 8'h30, 32'hFFFFFFFF, 3'b111);
    tick();
    set_usb(1'b1, 1'b0, 8'h30, 32'h00001200, 3'b010);
    tick();
    set_usb(1'b1, 1'b0, 8'h30, 32'h0, 3'b000);
    n_cmp++; if (bus.usb_rvalid !== 1'b0) begin n_bad++; $display("FAIL lane_wr_no_rvalid: got %b need 0", bus.usb_rvalid); end
    tick();
    set_usb(1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
    n_cmp++; if (bus.usb_rvalid !== 1'b1 || bus.usb_rdata !== 32'hFFFF12FF) begin
      n_bad++; $display("FAIL lane_mid: got v=%b %h need v=1 ffff12ff", bus.usb_rvalid, bus.usb_rdata); end
    set_cpu(1'b1, 8'h30, 32'hABCD0000, 3'b100);
    tick();
    set_cpu(1'b1, 8'h30, 32'h0, 3'b000);
    tick();
    set_cpu(1'b0, 8'h00, 32'h0, 3'b000);
    n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hABCD12FF) begin
      n_bad++; $display("FAIL lane_hi: got v=%b %h need v=1 abcd12ff", bus.cpu_rvalid, bus.cpu_rdata); end
  endtask

  task automatic test_lock_burst();
    tick();
    set_cpu(1'b1, 8'h10, 32'h0, 3'b000);
    for (int b = 1; b <= 8; b++) begin
      set_usb(1'b1, (b < 8), 8'h30, 32'h0, 3'b000);
      #1;
      n_cmp++; if ({bus.usb_gnt, bus.cpu_gnt} !== 2'b10) begin
        n_bad++; $display("FAIL burst_gnt[%0d]: got usb/cpu=%b%b need 10", b, bus.usb_gnt, bus.cpu_gnt); end
      tick();
      n_cmp++; if (bus.lock_active !== (b < 8)) begin
        n_bad++; $display("FAIL burst_lock_active[%0d]: got %b need %b", b, bus.lock_active, (b < 8)); end
      n_cmp++; if (bus.usb_rvalid !== 1'b1 || bus.usb_rdata !== 32'hABCD12FF) begin
        n_bad++; $display("FAIL burst_rdata[%0d]: got v=%b %h need v=1 abcd12ff", b, bus.usb_rvalid, bus.usb_rdata); end
    end
    set_usb(1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
    #1;
    n_cmp++; if (bus.cpu_gnt !== 1'b1) begin n_bad++; $display("FAIL burst_cpu_after: got %b need 1", bus.cpu_gnt); end
    tick();
    set_cpu(1'b0, 8'h00, 32'h0, 3'b000);
    n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL burst_cpu_data: got v=%b %h need v=1 deadbeef", bus.cpu_rvalid, bus.cpu_rdata); end
  endtask

  task automatic test_timeout();
    int exit_cyc = 0;
    int cpu_in_lock = 0;
    int usb_in_lock = 0;
    logic g65_cpu = 1'b0;
    logic g65_usb = 1'b1;
    logic to_at_exit = 1'b0;
    tick();
    // Pointer favours CPU after the burst's contended first beat.
    set_cpu(1'b1, 8'h10, 32'h0, 3'b000);
    set_usb(1'b1, 1'b0, 8'h30, 32'h0, 3'b000);
    #1;
    n_cmp++; if (bus.cpu_gnt !== 1'b1) begin n_bad++; $display("FAIL to_pre_gnt: got %b need 1", bus.cpu_gnt); end
    tick();
    set_usb(1'b1, 1'b1, 8'h30, 32'h0, 3'b000);
    for (int c = 1; c <= 70; c++) begin
      #1;
      if (c <= 64 && bus.cpu_gnt) cpu_in_lock++;
      if (c <= 64 && bus.usb_gnt) usb_in_lock++;
      if (c == 65) begin g65_cpu = bus.cpu_gnt; g65_usb = bus.usb_gnt; end
      tick();
      if (exit_cyc == 0 && !bus.lock_active) begin exit_cyc = c; to_at_exit = bus.lock_timeout; end
    end
    n_cmp++; if (exit_cyc !== 64) begin n_bad++; $display("FAIL to_exit_cycle: got %0d need 64", exit_cyc); end
    n_cmp++; if (cpu_in_lock !== 0) begin n_bad++; $display("FAIL to_cpu_blocked: got %0d grants need 0", cpu_in_lock); end
    n_cmp++; if (usb_in_lock !== 64) begin n_bad++; $display("FAIL to_usb_beats: got %0d need 64", usb_in_lock); end
    n_cmp++; if (to_at_exit !== 1'b1) begin n_bad++; $display("FAIL to_flag: got %b need 1", to_at_exit); end
    n_cmp++; if ({g65_cpu, g65_usb} !== 2'b10) begin
      n_bad++; $display("FAIL to_next_gnt: got cpu/usb=%b%b need 10", g65_cpu, g65_usb); end
    set_cpu(1'b0, 8'h00, 32'h0, 3'b000);
    set_usb(1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
    tick();
    n_cmp++; if ({bus.lock_timeout, bus.lock_active} !== 2'b10) begin
      n_bad++; $display("FAIL to_sticky: got to/la=%b%b need 10", bus.lock_timeout, bus.lock_active); end
  endtask

  task automatic test_reset_mid_lock();
    set_usb(1'b1, 1'b1, 8'h30, 32'h0, 3'b000);
    #1;
    n_cmp++; if (bus.usb_gnt !== 1'b1) begin n_bad++; $display("FAIL mid_gnt: got %b need 1", bus.usb_gnt); end
    tick();
    n_cmp++; if ({bus.lock_active, bus.usb_rvalid} !== 2'b11) begin
      n_bad++; $display("FAIL mid_pre: got la/rv=%b%b need 11", bus.lock_active, bus.usb_rvalid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.cpu_gnt, bus.usb_gnt, bus.cpu_rvalid, bus.usb_rvalid, bus.lock_active, bus.lock_timeout} !== 6'b0) begin
      n_bad++; $display("FAIL mid_rst_ctrl: got %b need 000000",
                        {bus.cpu_gnt, bus.usb_gnt, bus.cpu_rvalid, bus.usb_rvalid, bus.lock_active, bus.lock_timeout}); end
    n_cmp++; if ({bus.cpu_rdata, bus.usb_rdata} !== 64'h0) begin
      n_bad++; $display("FAIL mid_rst_data: got %h need 0", {bus.cpu_rdata, bus.usb_rdata}); end
    set_usb(1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
    #1 rst_n = 1'b1;
    tick();
    n_cmp++; if ({bus.cpu_rvalid, bus.usb_rvalid, bus.lock_active, bus.lock_timeout} !== 4'b0) begin
      n_bad++; $display("FAIL mid_post: got %b need 0000", {bus.cpu_rvalid, bus.usb_rvalid, bus.lock_active, bus.lock_timeout}); end
  endtask

  task automatic test_ram_retained();
    set_cpu(1'b1, 8'h10, 32'h0, 3'b000);
    tick();
    set_cpu(1'b0, 8'h00, 32'h0, 3'b000);
    n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL ram_retained: got v=%b %h need v=1 deadbeef", bus.cpu_rvalid, bus.cpu_rdata); end
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    test_alternate();
    test_lane_write();
    test_lock_burst();
    test_timeout();
    test_reset_mid_lock();
    test_ram_retained();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
